// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the RV32 datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath strobes as Moore outputs of (state, latched opcode). It also
// counts retired instructions and parks in TRAP on an illegal opcode.
// Optional feature macro: MEM_WAIT_EN (MEM waits for mem_ready).
module multicycle_ctrl #(
    parameter int CNT_W      = 32,
    parameter int FETCH_WAIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             stall,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ir_we,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       ALUOp,
    output logic             Branch,
    output logic             jump,
    output logic             RWSel,
    output logic [2:0]       state_o,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [3:0] FW = 4'(FETCH_WAIT);

    state_t     state, next_state;
    logic [6:0] opcode_q;
    logic [3:0] wait_cnt;
    logic       mem_done;

    logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui;

    // Legality of the live opcode; only consulted while in DECODE.
    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_LUI: is_legal = 1'b1;
            default:                                                is_legal = 1'b0;
        endcase
    endfunction

`ifdef MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    // mem_ready is ignored; MEM always completes in one cycle.
    logic mem_ready_unused;
    assign mem_ready_unused = mem_ready;
    assign mem_done         = 1'b1;
`endif

    // Strobes decode from the latched opcode, never the live IR field.
    assign is_r    = (opcode_q == OP_R);
    assign is_i    = (opcode_q == OP_I);
    assign is_lw   = (opcode_q == OP_LW);
    assign is_sw   = (opcode_q == OP_SW);
    assign is_br   = (opcode_q == OP_BR);
    assign is_jal  = (opcode_q == OP_JAL);
    assign is_jalr = (opcode_q == OP_JALR);
    assign is_lui  = (opcode_q == OP_LUI);

    assign state_o = state;

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // FETCH wait counter, frozen by stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (!stall) begin
            if (state == S_FETCH && wait_cnt != FW) wait_cnt <= wait_cnt + 4'd1;
            else                                    wait_cnt <= 4'd0;
        end
    end

    // Opcode latch, captured only on an unstalled DECODE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                             opcode_q <= 7'd0;
        else if (!stall && state == S_DECODE)  opcode_q <= Opcode;
    end

    // Retired counter and sticky illegal flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret <= '0;
            illegal <= 1'b0;
        end else begin
            if (instr_done)           instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
            if (next_state == S_TRAP) illegal <= 1'b1;
        end
    end

    // Next-state and Moore strobe decode; stall overrides at the end.
    always_comb begin
        next_state = state;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        ALUSrc     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        ALUOp      = 2'b00;
        Branch     = 1'b0;
        jump       = 1'b0;
        RWSel      = 1'b0;
        instr_done = 1'b0;
        case (state)
            S_FETCH: begin
                if (wait_cnt == FW) begin
                    pc_we      = 1'b1;
                    ir_we      = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                next_state = is_legal(Opcode) ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                ALUSrc = is_lw | is_sw | is_i | is_lui;
                if (is_br)              ALUOp = 2'b01;
                else if (is_r || is_i)  ALUOp = 2'b10;
                else if (is_lui)        ALUOp = 2'b11;
                else                    ALUOp = 2'b00;
                if (is_br) begin
                    Branch     = 1'b1;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end else if (is_jal) begin
                    jump       = 1'b1;
                    pc_we      = 1'b1;
                    next_state = S_WB;
                end else if (is_jalr) begin
                    pc_we      = 1'b1;
                    next_state = S_WB;
                end else if (is_lw || is_sw) begin
                    next_state = S_MEM;
                end else begin
                    next_state = S_WB;
                end
            end
            S_MEM: begin
                // Read/write stay up while waiting; memory acts on mem_done.
                MemRead  = is_lw;
                MemWrite = is_sw;
                if (mem_done) begin
                    if (is_lw) begin
                        next_state = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        next_state = S_FETCH;
                    end
                end
            end
            S_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = is_lw;
                RWSel      = is_jal | is_jalr;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_TRAP: begin
                next_state = S_TRAP;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
        if (stall) begin
            next_state = state;
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle expected state/strobes are queued as
// each scenario is built, then popped and compared as the DUT steps.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] Opcode = 7'h7F;
    logic       stall = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_we, ir_we, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
    logic [1:0] ALUOp;
    logic       Branch, jump, RWSel, instr_done, illegal;
    logic [2:0] state_o;
    logic [3:0] instret;

    int checks = 0;
    int failures = 0;
    logic [3:0] exp_cnt = 4'd0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(4), .FETCH_WAIT(0)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .stall(stall), .mem_ready(mem_ready),
        .pc_we(pc_we), .ir_we(ir_we), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .ALUOp(ALUOp),
        .Branch(Branch), .jump(jump), .RWSel(RWSel), .state_o(state_o),
        .instr_done(instr_done), .illegal(illegal), .instret(instret)
    );

    wire [12:0] strobes = {pc_we, ir_we, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                           ALUOp, Branch, jump, RWSel, instr_done};

    localparam logic [12:0] PC = 13'h1000, IR = 13'h0800, SRC = 13'h0400, M2R = 13'h0200;
    localparam logic [12:0] RW = 13'h0100, MR = 13'h0080, MW = 13'h0040;
    localparam logic [12:0] OP01 = 13'h0010, OP10 = 13'h0020, OP11 = 13'h0030;
    localparam logic [12:0] BR = 13'h0008, JP = 13'h0004, RWS = 13'h0002, DN = 13'h0001;

    localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LW_OP = 7'b0000011;
    localparam logic [6:0] SW_OP = 7'b0100011, BR_OP = 7'b1100011, JAL_OP = 7'b1101111;
    localparam logic [6:0] JALR_OP = 7'b1100111, LUI_OP = 7'b0110111, BAD_OP = 7'b1111111;

    typedef struct packed {
        logic        stall;
        logic        mr;
        logic [6:0]  op;
        logic [2:0]  st;
        logic [12:0] strb;
        logic        ill;
    } exp_t;

    exp_t sbq[$];
    exp_t e;

    task automatic push(input logic s, input logic m, input logic [6:0] op,
                        input logic [2:0] st, input logic [12:0] strb, input logic ill);
        exp_t x;
        x.stall = s; x.mr = m; x.op = op; x.st = st; x.strb = strb; x.ill = ill;
        sbq.push_back(x);
    endtask

    // Expected cycle-by-cycle trace of one unstalled instruction.
    task automatic push_instr(input logic [6:0] op);
        push(0, 1, BAD_OP, 3'd0, PC | IR, 0);
        push(0, 1, op,     3'd1, 13'h0,   0);
        case (op)
            R_OP:    begin push(0,1,BAD_OP,3'd2,OP10,0);        push(0,1,BAD_OP,3'd4,RW|DN,0); end
            I_OP:    begin push(0,1,BAD_OP,3'd2,SRC|OP10,0);    push(0,1,BAD_OP,3'd4,RW|DN,0); end
            LUI_OP:  begin push(0,1,BAD_OP,3'd2,SRC|OP11,0);    push(0,1,BAD_OP,3'd4,RW|DN,0); end
            LW_OP:   begin push(0,1,BAD_OP,3'd2,SRC,0);         push(0,1,BAD_OP,3'd3,MR,0);
                           push(0,1,BAD_OP,3'd4,M2R|RW|DN,0); end
            SW_OP:   begin push(0,1,BAD_OP,3'd2,SRC,0);         push(0,1,BAD_OP,3'd3,MW|DN,0); end
            BR_OP:   begin push(0,1,BAD_OP,3'd2,BR|OP01|PC|DN,0); end
            JAL_OP:  begin push(0,1,BAD_OP,3'd2,JP|PC,0);       push(0,1,BAD_OP,3'd4,RW|RWS|DN,0); end
            JALR_OP: begin push(0,1,BAD_OP,3'd2,PC,0);          push(0,1,BAD_OP,3'd4,RW|RWS|DN,0); end
            default: ;
        endcase
        exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (state_o !== 3'd0 || strobes !== (PC | IR) || instret !== 4'd0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset: state=%0d strobes=%h instret=%0d illegal=%b, want 0/%h/0/0",
                     state_o, strobes, instret, illegal, PC | IR);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 4'd0;
    endtask

    task automatic test_alu();
        push_instr(R_OP); push_instr(I_OP); push_instr(LUI_OP);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            stall = e.stall; mem_ready = e.mr; Opcode = e.op;
            #1;
            checks++;
            if (state_o !== e.st || strobes !== e.strb || illegal !== e.ill) begin
                failures++;
                $display("FAIL alu: state=%0d strobes=%h illegal=%b, want %0d/%h/%b",
                         state_o, strobes, illegal, e.st, e.strb, e.ill);
            end
            @(negedge clk);
        end
        checks++;
        if (instret !== exp_cnt) begin
            failures++;
            $display("FAIL alu_instret: got %0d want %0d", instret, exp_cnt);
        end
    endtask

    task automatic test_load();
        // Stalled FETCH suppresses pc_we/ir_we and holds the state.
        push(1, 1, BAD_OP, 3'd0, 13'h0, 0);
        push(1, 1, BAD_OP, 3'd0, 13'h0, 0);
        push_instr(LW_OP);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            stall = e.stall; mem_ready = e.mr; Opcode = e.op;
            #1;
            checks++;
            if (state_o !== e.st || strobes !== e.strb || illegal !== e.ill) begin
                failures++;
                $display("FAIL load: state=%0d strobes=%h illegal=%b, want %0d/%h/%b",
                         state_o, strobes, illegal, e.st, e.strb, e.ill);
            end
            @(negedge clk);
        end
        checks++;
        if (instret !== exp_cnt) begin
            failures++;
            $display("FAIL load_instret: got %0d want %0d", instret, exp_cnt);
        end
    endtask

    task automatic test_branch_jump();
        push_instr(BR_OP); push_instr(JAL_OP); push_instr(JALR_OP);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            stall = e.stall; mem_ready = e.mr; Opcode = e.op;
            #1;
            checks++;
            if (state_o !== e.st || strobes !== e.strb || illegal !== e.ill) begin
                failures++;
                $display("FAIL branch_jump: state=%0d strobes=%h illegal=%b, want %0d/%h/%b",
                         state_o, strobes, illegal, e.st, e.strb, e.ill);
            end
            @(negedge clk);
        end
        checks++;
        if (instret !== exp_cnt) begin
            failures++;
            $display("FAIL branch_jump_instret: got %0d want %0d", instret, exp_cnt);
        end
    endtask

    task automatic test_store_stall();
        push(0, 1, BAD_OP, 3'd0, PC | IR, 0);
        push(1, 1, BAD_OP, 3'd1, 13'h0, 0);   // stalled DECODE must not trap on junk
        push(0, 1, SW_OP,  3'd1, 13'h0, 0);
        push(0, 1, BAD_OP, 3'd2, SRC, 0);
        push(1, 1, BAD_OP, 3'd3, 13'h0, 0);
        push(1, 1, BAD_OP, 3'd3, 13'h0, 0);
        push(1, 1, BAD_OP, 3'd3, 13'h0, 0);
        push(0, 1, BAD_OP, 3'd3, MW | DN, 0);
        push(0, 1, BAD_OP, 3'd0, PC | IR, 0);
        exp_cnt = exp_cnt + 4'd1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            stall = e.stall; mem_ready = e.mr; Opcode = e.op;
            #1;
            checks++;
            if (state_o !== e.st || strobes !== e.strb || illegal !== e.ill) begin
                failures++;
                $display("FAIL store_stall: state=%0d strobes=%h illegal=%b, want %0d/%h/%b",
                         state_o, strobes, illegal, e.st, e.strb, e.ill);
            end
            if (sbq.size() > 0) @(negedge clk);
        end
        checks++;
        if (instret !== exp_cnt) begin
            failures++;
            $display("FAIL store_stall_instret: got %0d want %0d", instret, exp_cnt);
        end
        @(negedge clk);
        // The extra unstalled FETCH above already moved the DUT to DECODE; finish with a BR.
        push(0, 1, BR_OP,  3'd1, 13'h0, 0);
        push(0, 1, BAD_OP, 3'd2, BR | OP01 | PC | DN, 0);
        exp_cnt = exp_cnt + 4'd1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            stall = e.stall; mem_ready = e.mr; Opcode = e.op;
            #1;
            checks++;
            if (state_o !== e.st || strobes !== e.strb || illegal !== e.ill) begin
                failures++;
                $display("FAIL store_tail: state=%0d strobes=%h illegal=%b, want %0d/%h/%b",
                         state_o, strobes, illegal, e.st, e.strb, e.ill);
            end
            @(negedge clk);
        end
    endtask

`ifdef MEM_WAIT_EN
    task automatic test_mem_wait();
        push(0, 1, BAD_OP, 3'd0, PC | IR, 0);
        push(0, 1, LW_OP,  3'd1, 13'h0, 0);
        push(0, 1, BAD_OP, 3'd2, SRC, 0);
        for (int i = 0; i < 4; i++) push(0, 0, BAD_OP, 3'd3, MR, 0);
        push(0, 1, BAD_OP, 3'd3, MR, 0);
        push(0, 1, BAD_OP, 3'd4, M2R | RW | DN, 0);
        push(0, 1, BAD_OP, 3'd0, PC | IR, 0);
        push(0, 1, SW_OP,  3'd1, 13'h0, 0);
        push(0, 1, BAD_OP, 3'd2, SRC, 0);
        push(0, 0, BAD_OP, 3'd3, MW, 0);
        push(0, 0, BAD_OP, 3'd3, MW, 0);
        push(0, 1, BAD_OP, 3'd3, MW | DN, 0);
        exp_cnt = exp_cnt + 4'd2;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            stall = e.stall; mem_ready = e.mr; Opcode = e.op;
            #1;
            checks++;
            if (state_o !== e.st || strobes !== e.strb || illegal !== e.ill) begin
                failures++;
                $display("FAIL mem_wait: state=%0d strobes=%h illegal=%b, want %0d/%h/%b",
                         state_o, strobes, illegal, e.st, e.strb, e.ill);
            end
            @(negedge clk);
        end
        checks++;
        if (instret !== exp_cnt) begin
            failures++;
            $display("FAIL mem_wait_instret: got %0d want %0d", instret, exp_cnt);
        end
    endtask
`endif

    task automatic test_trap();
        push(0, 1, BAD_OP, 3'd0, PC | IR, 0);
        push(0, 1, BAD_OP, 3'd1, 13'h0, 0);
        for (int i = 0; i < 20; i++) push(0, 1, R_OP, 3'd7, 13'h0, 1);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            stall = e.stall; mem_ready = e.mr; Opcode = e.op;
            #1;
            checks++;
            if (state_o !== e.st || strobes !== e.strb || illegal !== e.ill) begin
                failures++;
                $display("FAIL trap: state=%0d strobes=%h illegal=%b, want %0d/%h/%b",
                         state_o, strobes, illegal, e.st, e.strb, e.ill);
            end
            @(negedge clk);
        end
        checks++;
        if (instret !== exp_cnt) begin
            failures++;
            $display("FAIL trap_instret: got %0d want %0d", instret, exp_cnt);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (state_o !== 3'd0 || illegal !== 1'b0 || instret !== 4'd0) begin
            failures++;
            $display("FAIL trap_reset: state=%0d illegal=%b instret=%0d, want 0/0/0",
                     state_o, illegal, instret);
        end
        exp_cnt = 4'd0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        for (int n = 0; n < 16; n++) begin
            push_instr(BR_OP);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                stall = e.stall; mem_ready = e.mr; Opcode = e.op;
                #1;
                checks++;
                if (state_o !== e.st || strobes !== e.strb || illegal !== e.ill) begin
                    failures++;
                    $display("FAIL wrap_seq: state=%0d strobes=%h illegal=%b, want %0d/%h/%b",
                             state_o, strobes, illegal, e.st, e.strb, e.ill);
                end
                @(negedge clk);
            end
            if (n >= 14) begin
                checks++;
                if (instret !== exp_cnt) begin
                    failures++;
                    $display("FAIL wrap_instret: after %0d got %0d want %0d", n + 1, instret, exp_cnt);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_branch_jump();
        test_store_stall();
`ifdef MEM_WAIT_EN
        test_mem_wait();
`endif
        test_trap();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
